// File: rtl/tt_um_serial_adder_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell (two half adders + OR)
// processes WIDTH-bit operands LSB first, one bit per clock.
module tt_um_serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sh_q, res_q;
  logic [WIDTH:0]   sh_ext;
  logic [WIDTH-1:0] sh_next;
  logic [2:0]       cnt_q;
  logic             carry_q, sub_q, start_q, cout_q, ovf_q;

  logic load_a, load_b, load_any, start_rise, last_bit;
  logic b_bit, h1_s, h1_c, sum_bit, h2_c, c_next;
  logic busy, done;
  logic unused_ok;

  assign load_a     = uio_in[0];
  assign load_b     = uio_in[1];
  assign load_any   = load_a | load_b;
  assign start_rise = uio_in[2] & ~start_q;
  assign last_bit   = (cnt_q == 3'(WIDTH-1));

  // Full adder built from two half adders; B is inverted for subtraction
  // and the initial carry supplies the +1 of two's complement.
  assign b_bit   = b_q[0] ^ sub_q;
  assign h1_s    = a_q[0] ^ b_bit;
  assign h1_c    = a_q[0] & b_bit;
  assign sum_bit = h1_s ^ carry_q;
  assign h2_c    = h1_s & carry_q;
  assign c_next  = h1_c | h2_c;

  assign sh_ext  = {sum_bit, sh_q};
  assign sh_next = sh_ext[WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (last_bit) state_d = S_DONE;
      end
      default: begin
        if (load_any)        state_d = S_IDLE;
        else if (start_rise) state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      start_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= uio_in[2];
      if (state_q == S_RUN) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        sh_q    <= sh_next;
        carry_q <= c_next;
        cnt_q   <= cnt_q + 3'd1;
        if (last_bit) begin
          res_q  <= sh_next;
          cout_q <= c_next;
          // carry_q here is the carry into the MSB
          ovf_q  <= carry_q ^ c_next;
        end
      end else if (load_any) begin
        if (load_a) a_q <= ui_in[WIDTH-1:0];
        if (load_b) b_q <= ui_in[WIDTH-1:0];
      end else if (start_rise) begin
        sub_q   <= uio_in[3];
        carry_q <= uio_in[3];
        cnt_q   <= '0;
        cout_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end
    end
  end

  assign uo_out    = 8'(res_q);
  assign uio_out   = {ovf_q, cout_q, done, busy, 4'b0000};
  assign uio_oe    = 8'hF0;
  assign unused_ok = &{1'b0, ena, uio_in[7:4], ui_in};

endmodule

// File: tb/tb_tt_um_serial_adder_seq.sv
// Directed and randomized bench for the bit-serial adder, checked against an
// integer-arithmetic reference model.
module tb_tt_um_serial_adder_seq;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;

  tt_um_serial_adder_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int a, input int b, input bit sub,
                                output int res, output bit cout, output bit ovf);
    int sa, sb, sr;
    int mask;
    mask = (1 << W) - 1;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    if (sub) begin
      res  = (a - b) & mask;
      cout = (a >= b);
      sr   = sa - sb;
    end else begin
      res  = (a + b) & mask;
      cout = ((a + b) > mask);
      sr   = sa + sb;
    end
    ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endfunction

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    uio_in = 8'h01; ui_in = a; tick();
    uio_in = 8'h02; ui_in = b; tick();
    uio_in = 8'h00; ui_in = 8'h00; tick();
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit sub,
                       input bit intrude);
    int res;
    bit cout, ovf;
    model(int'(a), int'(b), sub, res, cout, ovf);
    load(a, b);
    uio_in = {4'b0, sub, 3'b100};
    tick();
    uio_in = 8'h00;
    check("busy_first", {7'b0, uio_out[4]}, 8'd1);
    for (int i = 1; i < int'(W); i++) begin
      if (intrude && i == 3) begin
        uio_in = 8'h05; ui_in = 8'hAA;
      end
      tick();
      uio_in = 8'h00; ui_in = 8'h00;
      check("busy_run", {7'b0, uio_out[4]}, 8'd1);
    end
    tick();
    check("busy_end", {7'b0, uio_out[4]}, 8'd0);
    check("done", {7'b0, uio_out[5]}, 8'd1);
    check("result", uo_out, 8'(res));
    check("carry_out", {7'b0, uio_out[6]}, {7'b0, cout});
    check("overflow", {7'b0, uio_out[7]}, {7'b0, ovf});
  endtask

  initial begin
    int busy_cycles;

    // Reset state
    tick(); tick();
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    tick();
    check("idle_uio_out", uio_out, 8'h00);

    // Directed arithmetic cases
    do_op(8'h2D, 8'h3C, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0);

    // Load and start during a run are ignored
    do_op(8'h2D, 8'h3C, 1'b0, 1'b1);
    check("intrude_result", uo_out, 8'h69);
    uio_in = 8'h01; ui_in = 8'h11; tick();
    uio_in = 8'h00; ui_in = 8'h00;
    check("load_clears_done", {7'b0, uio_out[5]}, 8'd0);
    check("load_idle_busy", {7'b0, uio_out[4]}, 8'd0);
    check("load_keeps_result", uo_out, 8'h69);

    // Held start gives exactly one operation
    load(8'h01, 8'h01);
    busy_cycles = 0;
    uio_in = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uio_out[4]) busy_cycles++;
    end
    check("held_busy_cycles", 8'(busy_cycles), 8'(W));
    check("held_result", uo_out, 8'h02);
    check("held_done", {7'b0, uio_out[5]}, 8'd1);
    uio_in = 8'h00; tick();

    // Load in same cycle as start rise wins
    uio_in = 8'h01; ui_in = 8'h03; tick();
    uio_in = 8'h00; tick();
    uio_in = 8'h05; ui_in = 8'h04; tick();
    check("load_start_busy", {7'b0, uio_out[4]}, 8'd0);
    uio_in = 8'h00; ui_in = 8'h00; tick();
    check("load_start_busy2", {7'b0, uio_out[4]}, 8'd0);
    tick();
    check("load_start_busy3", {7'b0, uio_out[4]}, 8'd0);

    // Asynchronous reset mid-run
    load(8'h55, 8'h22);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (4) tick();
    check("pre_rst_busy", {7'b0, uio_out[4]}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo_out", uo_out, 8'h00);
    check("mid_rst_uio_out", uio_out, 8'h00);
    #4;
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", uio_out, 8'h00);
    do_op(8'h10, 8'h20, 1'b0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
